// File: rtl/vga_text_writer.sv
// Writer side of the text-mode video memory: consumes a character stream, keeps a
// hardware cursor, and issues per-cell VM port A writes for characters and clears.
module vga_text_writer #(
    parameter int unsigned COLS           = 32,
    parameter int unsigned ROWS           = 30,
    parameter logic [7:0]  BLANK          = 8'h20,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic        clk_50mhz,
    input  logic        rst_n,
    input  logic        char_valid,
    input  logic [7:0]  char_data,
    output logic        char_ready,
    input  logic        clear_req,
    output logic        vm_we,
    output logic [11:0] vm_addr,
    output logic [7:0]  vm_din,
    output logic [4:0]  cursor_col,
    output logic [4:0]  cursor_row,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, CLR_ALL, CLR_LINE, RESET_CLR} state_t;

    localparam logic [4:0] COL_MAX = 5'(COLS - 1);
    localparam logic [4:0] ROW_MAX = 5'(ROWS - 1);
    localparam logic [7:0] CH_BS   = 8'h08;
    localparam logic [7:0] CH_LF   = 8'h0A;
    localparam logic [7:0] CH_FF   = 8'h0C;
    localparam logic [7:0] CH_CR   = 8'h0D;
    localparam state_t     RESET_STATE = CLEAR_ON_RESET ? RESET_CLR : IDLE;

    state_t     state, state_nxt;
    logic [4:0] clr_col, clr_row;
    logic [4:0] row_adv;
    logic       accept, printable, clr_col_last, clr_all_last;

    assign accept       = char_ready & char_valid;
    assign printable    = (char_data >= 8'h20) && (char_data <= 8'h7E);
    assign row_adv      = (cursor_row == ROW_MAX) ? '0 : cursor_row + 5'd1;
    assign clr_col_last = (clr_col == COL_MAX);
    assign clr_all_last = clr_col_last && (clr_row == ROW_MAX);

    always_ff @(posedge clk_50mhz or negedge rst_n) begin
        if (!rst_n) state <= RESET_STATE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (clear_req) begin
                    state_nxt = CLR_ALL;
                end else if (accept) begin
                    if (char_data == CH_FF)
                        state_nxt = CLR_ALL;
                    else if ((char_data == CH_LF) || (printable && cursor_col == COL_MAX))
                        state_nxt = CLR_LINE;
                end
            end
            CLR_ALL, RESET_CLR: if (clr_all_last) state_nxt = IDLE;
            CLR_LINE:           if (clr_col_last) state_nxt = IDLE;
            default:            state_nxt = IDLE;
        endcase
    end

    // char_ready is held low during reset; busy mirrors it only once out of reset
    always_comb begin
        char_ready = rst_n && (state == IDLE) && !clear_req;
        busy       = rst_n && !char_ready;
    end

    always_ff @(posedge clk_50mhz or negedge rst_n) begin
        if (!rst_n) begin
            vm_we      <= 1'b0;
            vm_addr    <= '0;
            vm_din     <= '0;
            cursor_col <= '0;
            cursor_row <= '0;
            clr_col    <= '0;
            clr_row    <= '0;
        end else begin
            vm_we <= 1'b0;
            unique case (state)
                IDLE: begin
                    clr_col <= '0;
                    clr_row <= '0;
                    if (accept) begin
                        if (printable) begin
                            vm_we   <= 1'b1;
                            vm_addr <= {2'b00, cursor_row, cursor_col};
                            vm_din  <= char_data;
                            if (cursor_col == COL_MAX) begin
                                cursor_col <= '0;
                                cursor_row <= row_adv;
                            end else begin
                                cursor_col <= cursor_col + 5'd1;
                            end
                        end else if (char_data == CH_LF) begin
                            cursor_col <= '0;
                            cursor_row <= row_adv;
                        end else if (char_data == CH_CR) begin
                            cursor_col <= '0;
                        end else if ((char_data == CH_BS) && (cursor_col != '0)) begin
                            cursor_col <= cursor_col - 5'd1;
                            vm_we      <= 1'b1;
                            vm_addr    <= {2'b00, cursor_row, cursor_col - 5'd1};
                            vm_din     <= BLANK;
                        end
                    end
                end
                CLR_ALL, RESET_CLR: begin
                    vm_we   <= 1'b1;
                    vm_addr <= {2'b00, clr_row, clr_col};
                    vm_din  <= BLANK;
                    if (clr_col_last) begin
                        clr_col <= '0;
                        clr_row <= clr_all_last ? '0 : clr_row + 5'd1;
                    end else begin
                        clr_col <= clr_col + 5'd1;
                    end
                    if (clr_all_last) begin
                        cursor_col <= '0;
                        cursor_row <= '0;
                    end
                end
                CLR_LINE: begin
                    // cursor_row already holds the advanced row
                    vm_we   <= 1'b1;
                    vm_addr <= {2'b00, cursor_row, clr_col};
                    vm_din  <= BLANK;
                    clr_col <= clr_col_last ? '0 : clr_col + 5'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_vga_text_writer.sv
// Scoreboard bench for vga_text_writer: a behavioural model queues expected VM writes
// as characters are accepted; each scenario task compares them against captured writes.
module tb_vga_text_writer;

    logic        clk_50mhz = 1'b0;
    logic        rst_n = 1'b1;
    logic        char_valid = 1'b0;
    logic [7:0]  char_data = '0;
    logic        char_ready;
    logic        clear_req = 1'b0;
    logic        vm_we;
    logic [11:0] vm_addr;
    logic [7:0]  vm_din;
    logic [4:0]  cursor_col, cursor_row;
    logic        busy;

    int          passed = 0;
    int          total  = 0;
    logic [19:0] exp_q[$];
    logic [19:0] obs_mem[4096];
    int unsigned obs_wr = 0;
    int unsigned obs_rd = 0;
    logic [4:0]  mrow = '0, mcol = '0;

    vga_text_writer #(.COLS(32), .ROWS(30), .BLANK(8'h20), .CLEAR_ON_RESET(1'b1)) dut (
        .clk_50mhz(clk_50mhz), .rst_n(rst_n), .char_valid(char_valid), .char_data(char_data),
        .char_ready(char_ready), .clear_req(clear_req), .vm_we(vm_we), .vm_addr(vm_addr),
        .vm_din(vm_din), .cursor_col(cursor_col), .cursor_row(cursor_row), .busy(busy)
    );

    always #10 clk_50mhz = ~clk_50mhz;

    always @(negedge clk_50mhz) begin
        if (rst_n === 1'b1 && vm_we === 1'b1) begin
            obs_mem[obs_wr % 4096] = {vm_addr, vm_din};
            obs_wr = obs_wr + 1;
        end
    end

    task automatic push_full_clear();
        for (int i = 0; i < 960; i++) exp_q.push_back({12'(i), 8'h20});
        mrow = '0;
        mcol = '0;
    endtask

    task automatic adv_line();
        mrow = (mrow == 5'd29) ? 5'd0 : mrow + 5'd1;
        for (int c = 0; c < 32; c++) exp_q.push_back({2'b00, mrow, 5'(c), 8'h20});
    endtask

    task automatic model(input logic [7:0] c);
        if (c >= 8'h20 && c <= 8'h7E) begin
            exp_q.push_back({2'b00, mrow, mcol, c});
            if (mcol == 5'd31) begin
                mcol = '0;
                adv_line();
            end else begin
                mcol = mcol + 5'd1;
            end
        end else if (c == 8'h0A) begin
            mcol = '0;
            adv_line();
        end else if (c == 8'h0D) begin
            mcol = '0;
        end else if (c == 8'h08) begin
            if (mcol != 0) begin
                mcol = mcol - 5'd1;
                exp_q.push_back({2'b00, mrow, mcol, 8'h20});
            end
        end else if (c == 8'h0C) begin
            push_full_clear();
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (char_ready !== 1'b1 && n < 3000) begin
            @(negedge clk_50mhz);
            n++;
        end
        if (char_ready !== 1'b1) begin
            $display("FAIL ready_timeout: char_ready=%b after %0d cycles, required 1", char_ready, n);
            $fatal(1, "char_ready never returned");
        end
    endtask

    task automatic wait_idle();
        @(negedge clk_50mhz);
        wait_ready();
        @(negedge clk_50mhz);
        #1;
    endtask

    task automatic send(input logic [7:0] c);
        @(negedge clk_50mhz);
        char_valid = 1'b1;
        char_data  = c;
        wait_ready();
        @(posedge clk_50mhz);
        model(c);
        #1;
        char_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [19:0] e, o;
        #5 rst_n = 1'b0;
        #1;
        total++;
        if ({vm_we, vm_addr, vm_din, cursor_row, cursor_col, busy, char_ready} !== '0)
            $display("FAIL reset_outputs: got we=%b addr=%h din=%h row=%0d col=%0d busy=%b rdy=%b, required all 0",
                     vm_we, vm_addr, vm_din, cursor_row, cursor_col, busy, char_ready);
        else passed++;
        repeat (3) @(posedge clk_50mhz);
        #1;
        total++;
        if (vm_we !== 1'b0) $display("FAIL reset_hold_we: got %b required 0", vm_we);
        else passed++;
        @(negedge clk_50mhz);
        rst_n = 1'b1;
        obs_rd = obs_wr;
        push_full_clear();
        wait_idle();
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            total++;
            if (obs_rd == obs_wr) $display("FAIL reset_clear_write: missing, required %h", e);
            else begin
                o = obs_mem[obs_rd % 4096];
                obs_rd++;
                if (o !== e) $display("FAIL reset_clear_write: got %h required %h", o, e);
                else passed++;
            end
        end
        total++;
        if (obs_rd != obs_wr) $display("FAIL reset_clear_extra: got %0d extra writes required 0", obs_wr - obs_rd);
        else passed++;
        obs_rd = obs_wr;
        total++;
        if ({char_ready, cursor_row, cursor_col} !== {1'b1, 10'd0})
            $display("FAIL reset_done: got rdy=%b row=%0d col=%0d required 1,0,0", char_ready, cursor_row, cursor_col);
        else passed++;
    endtask

    task automatic test_back_to_back();
        logic [19:0] e, o;
        @(negedge clk_50mhz);
        char_valid = 1'b1;
        char_data  = 8'h41;
        @(posedge clk_50mhz);
        model(8'h41);
        #1 char_data = 8'h42;
        @(negedge clk_50mhz);
        total++;
        if ({vm_we, vm_addr, vm_din, cursor_col} !== {1'b1, 12'h000, 8'h41, 5'd1})
            $display("FAIL b2b_first_latency: got we=%b addr=%h din=%h col=%0d required 1,000,41,1",
                     vm_we, vm_addr, vm_din, cursor_col);
        else passed++;
        @(posedge clk_50mhz);
        model(8'h42);
        #1 char_valid = 1'b0;
        @(negedge clk_50mhz);
        total++;
        if ({vm_we, vm_addr, vm_din, cursor_col} !== {1'b1, 12'h001, 8'h42, 5'd2})
            $display("FAIL b2b_second_latency: got we=%b addr=%h din=%h col=%0d required 1,001,42,2",
                     vm_we, vm_addr, vm_din, cursor_col);
        else passed++;
        wait_idle();
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            total++;
            if (obs_rd == obs_wr) $display("FAIL b2b_write: missing, required %h", e);
            else begin
                o = obs_mem[obs_rd % 4096];
                obs_rd++;
                if (o !== e) $display("FAIL b2b_write: got %h required %h", o, e);
                else passed++;
            end
        end
        total++;
        if (obs_rd != obs_wr) $display("FAIL b2b_extra: got %0d extra writes required 0", obs_wr - obs_rd);
        else passed++;
        obs_rd = obs_wr;
        send(8'h0D);
        send(8'h01);
        wait_idle();
        total++;
        if ({cursor_row, cursor_col} !== 10'd0 || obs_rd != obs_wr)
            $display("FAIL cr_ignore: got row=%0d col=%0d writes=%0d required 0,0,0",
                     cursor_row, cursor_col, obs_wr - obs_rd);
        else passed++;
    endtask

    task automatic test_line_wrap();
        logic [19:0] e, o;
        int n;
        repeat (5) send(8'h0A);
        for (int i = 0; i < 31; i++) send(8'h61 + 8'(i % 26));
        wait_idle();
        total++;
        if ({cursor_row, cursor_col} !== {5'd5, 5'd31})
            $display("FAIL wrap_setup_cursor: got (%0d,%0d) required (5,31)", cursor_row, cursor_col);
        else passed++;
        send(8'h5A);
        n = 0;
        @(negedge clk_50mhz);
        while (char_ready !== 1'b1 && n < 100) begin
            n++;
            @(negedge clk_50mhz);
        end
        total++;
        if (n != 32) $display("FAIL wrap_busy_cycles: got %0d required 32", n);
        else passed++;
        @(negedge clk_50mhz);
        #1;
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            total++;
            if (obs_rd == obs_wr) $display("FAIL wrap_write: missing, required %h", e);
            else begin
                o = obs_mem[obs_rd % 4096];
                obs_rd++;
                if (o !== e) $display("FAIL wrap_write: got %h required %h", o, e);
                else passed++;
            end
        end
        total++;
        if (obs_rd != obs_wr) $display("FAIL wrap_extra: got %0d extra writes required 0", obs_wr - obs_rd);
        else passed++;
        obs_rd = obs_wr;
        total++;
        if ({cursor_row, cursor_col} !== {5'd6, 5'd0})
            $display("FAIL wrap_cursor: got (%0d,%0d) required (6,0)", cursor_row, cursor_col);
        else passed++;
    endtask

    task automatic test_lf_row_wrap();
        logic [19:0] e, o;
        repeat (23) send(8'h0A);
        send(8'h78); send(8'h79); send(8'h7A);
        wait_idle();
        total++;
        if ({cursor_row, cursor_col} !== {5'd29, 5'd3})
            $display("FAIL lf_setup_cursor: got (%0d,%0d) required (29,3)", cursor_row, cursor_col);
        else passed++;
        send(8'h0A);
        wait_idle();
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            total++;
            if (obs_rd == obs_wr) $display("FAIL lf_write: missing, required %h", e);
            else begin
                o = obs_mem[obs_rd % 4096];
                obs_rd++;
                if (o !== e) $display("FAIL lf_write: got %h required %h", o, e);
                else passed++;
            end
        end
        total++;
        if (obs_rd != obs_wr) $display("FAIL lf_extra: got %0d extra writes required 0", obs_wr - obs_rd);
        else passed++;
        obs_rd = obs_wr;
        total++;
        if ({cursor_row, cursor_col} !== 10'd0)
            $display("FAIL lf_cursor: got (%0d,%0d) required (0,0)", cursor_row, cursor_col);
        else passed++;
    endtask

    task automatic test_backspace();
        logic [19:0] e, o;
        send(8'h0A);
        send(8'h0A);
        wait_idle();
        obs_rd = obs_wr;
        exp_q.delete();
        send(8'h08);
        wait_idle();
        total++;
        if ({cursor_row, cursor_col} !== {5'd2, 5'd0} || obs_rd != obs_wr)
            $display("FAIL bs_col0: got (%0d,%0d) writes=%0d required (2,0) writes=0",
                     cursor_row, cursor_col, obs_wr - obs_rd);
        else passed++;
        send(8'h31); send(8'h32); send(8'h33); send(8'h34);
        send(8'h08);
        wait_idle();
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            total++;
            if (obs_rd == obs_wr) $display("FAIL bs_write: missing, required %h", e);
            else begin
                o = obs_mem[obs_rd % 4096];
                obs_rd++;
                if (o !== e) $display("FAIL bs_write: got %h required %h", o, e);
                else passed++;
            end
        end
        total++;
        if (obs_rd != obs_wr) $display("FAIL bs_extra: got %0d extra writes required 0", obs_wr - obs_rd);
        else passed++;
        obs_rd = obs_wr;
        total++;
        if ({cursor_row, cursor_col} !== {5'd2, 5'd3})
            $display("FAIL bs_cursor: got (%0d,%0d) required (2,3)", cursor_row, cursor_col);
        else passed++;
    endtask

    task automatic test_clear_priority();
        logic [19:0] e, o;
        @(negedge clk_50mhz);
        clear_req  = 1'b1;
        char_valid = 1'b1;
        char_data  = 8'h51;
        #1;
        total++;
        if ({char_ready, busy} !== 2'b01)
            $display("FAIL clr_prio_comb: got rdy=%b busy=%b required 0,1", char_ready, busy);
        else passed++;
        @(posedge clk_50mhz);
        push_full_clear();
        @(negedge clk_50mhz);
        clear_req = 1'b0;
        wait_ready();
        @(posedge clk_50mhz);
        model(8'h51);
        #1 char_valid = 1'b0;
        wait_idle();
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            total++;
            if (obs_rd == obs_wr) $display("FAIL clr_prio_write: missing, required %h", e);
            else begin
                o = obs_mem[obs_rd % 4096];
                obs_rd++;
                if (o !== e) $display("FAIL clr_prio_write: got %h required %h", o, e);
                else passed++;
            end
        end
        total++;
        if (obs_rd != obs_wr) $display("FAIL clr_prio_extra: got %0d extra writes required 0", obs_wr - obs_rd);
        else passed++;
        obs_rd = obs_wr;
        total++;
        if ({cursor_row, cursor_col} !== {5'd0, 5'd1})
            $display("FAIL clr_prio_cursor: got (%0d,%0d) required (0,1)", cursor_row, cursor_col);
        else passed++;
    endtask

    task automatic test_reset_mid_line();
        logic [19:0] e, o;
        send(8'h0A);
        repeat (5) @(negedge clk_50mhz);
        total++;
        if (vm_we !== 1'b1) $display("FAIL midrst_pre_we: got %b required 1", vm_we);
        else passed++;
        #3 rst_n = 1'b0;
        #1;
        total++;
        if ({vm_we, vm_addr, vm_din, cursor_row, cursor_col, busy, char_ready} !== '0)
            $display("FAIL midrst_async: got we=%b addr=%h din=%h row=%0d col=%0d busy=%b rdy=%b, required all 0",
                     vm_we, vm_addr, vm_din, cursor_row, cursor_col, busy, char_ready);
        else passed++;
        while (obs_rd != obs_wr) begin
            e = exp_q.pop_front();
            o = obs_mem[obs_rd % 4096];
            obs_rd++;
            total++;
            if (o !== e) $display("FAIL midrst_partial_write: got %h required %h", o, e);
            else passed++;
        end
        exp_q.delete();
        repeat (2) @(negedge clk_50mhz);
        rst_n = 1'b1;
        push_full_clear();
        wait_idle();
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            total++;
            if (obs_rd == obs_wr) $display("FAIL midrst_clear_write: missing, required %h", e);
            else begin
                o = obs_mem[obs_rd % 4096];
                obs_rd++;
                if (o !== e) $display("FAIL midrst_clear_write: got %h required %h", o, e);
                else passed++;
            end
        end
        total++;
        if (obs_rd != obs_wr) $display("FAIL midrst_extra: got %0d extra writes required 0", obs_wr - obs_rd);
        else passed++;
        obs_rd = obs_wr;
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_line_wrap();
        test_lf_row_wrap();
        test_backspace();
        test_clear_priority();
        test_reset_mid_line();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
